calc_seq: RTL and testbench
===========================

# calc_seq

Sequencing controller for the shared 6-bit add/subtract unit in the calculator datapath. It accepts one command at a time under a START/BUSY/DONE handshake and drives a single `addandsub` instance. ADD and SUB take one pass through the unit. MUL and MAC are built as a fixed 6-iteration shift-and-add loop on the same unit. It sits between the calculator front-end (operand/opcode capture) and the result display/register logic.

## Interface
- `WIDTH`, default 6: datapath width. Only 6 is supported, because it must match `addandsub`.
- `CLK` in 1: single clock; everything is rising-edge.
- `RST` in 1: synchronous, active-high reset.
- `START` in 1: command request; sampled only in IDLE.
- `OP` in 2: opcode, sampled with START.
  - 00 ADD, 01 SUB, 10 MUL, 11 MAC.
- `A_DATA` in 6: operand A / multiplicand; unsigned for MUL/MAC.
- `B_DATA` in 6: operand B / multiplier; unsigned for MUL/MAC.
- `BUSY` out 1: high from the cycle after an accepted START through the last RUN cycle.
- `DONE` out 1: one-cycle pulse when RESULT is updated.
- `RESULT` out 6: last completed result; holds until the next DONE.

## Operation
- States: IDLE, RUN, FIN.
- IDLE → RUN when START=1.
  - Latch OP, A_DATA → mcand, B_DATA → mplier.
  - acc ← 0 for ADD/SUB/MUL; acc ← RESULT for MAC.
  - cnt ← 1 for ADD/SUB; cnt ← 6 for MUL/MAC.
- ADD/SUB RUN cycle:
  - Adder inputs: A = mcand, B = mplier, SUB_SEL = (OP==SUB).
  - acc ← adder output.
- MUL/MAC RUN cycle:
  - Adder inputs: A = acc, B = mcand, SUB_SEL = 0.
  - If mplier[0]=1, acc ← adder output; otherwise acc holds.
  - Then mcand ← mcand<<1 (zero fill), mplier ← mplier>>1.
- Every RUN cycle: cnt ← cnt−1. Leave RUN for FIN when cnt=1.
- FIN: RESULT ← acc, DONE=1, then → IDLE. FIN lasts exactly one cycle.
- Arithmetic is modulo 64, with no carry or overflow output.
  - SUB yields two's-complement wrap.
  - MUL yields (A·B) mod 64.
  - MAC yields (RESULT_prev + A·B) mod 64.
- No early termination: MUL/MAC always take 6 RUN cycles, even when the multiplier is 0.
- START while BUSY=1 or in FIN: ignored, with no queuing. A START held high in the FIN cycle is not accepted; it is accepted in the following IDLE cycle.
- An undefined OP cannot occur (2-bit code is fully decoded).

## Timing
- START accepted in cycle N.
  - BUSY=1 from N+1.
  - ADD/SUB: RUN in N+1, FIN (DONE=1, RESULT valid, BUSY=0) in N+2. Latency 2.
  - MUL/MAC: RUN in N+1..N+6, FIN in N+7. Latency 7.
- Maximum throughput: one command every 3 cycles (ADD/SUB) or 8 cycles (MUL/MAC).
- Reset values: state=IDLE, BUSY=0, DONE=0, RESULT=0, acc/mcand/mplier/cnt=0.
- RST during RUN or FIN: the operation is aborted with no DONE. All outputs take reset values on the next cycle.
- RST has priority over START in the same cycle.
- The adder path is combinational within one cycle: acc → `addandsub` → acc register. No multicycle path.

## Structure
- Shared package `calc_pkg` holds:
  - the OP encodings (OP_ADD, OP_SUB, OP_MUL, OP_MAC);
  - the state encoding (ST_IDLE, ST_RUN, ST_FIN);
  - the constants CALC_WIDTH=6 and MUL_ITERS=6.
- Sub-module: exactly one instance of the existing `addandsub`, fed by a 2-way operand mux in front of its A input (mcand vs acc).
- The FSM, counter and shift registers stay in `calc_seq`; no further sub-modules.

## Test plan
- ADD: A=0x25, B=0x1A in cycle N → DONE and RESULT=0x3F in N+2; BUSY=1 only in N+1.
- SUB wrap: A=0x05, B=0x07 → RESULT=0x3E.
- SUB zero: A=0x3F, B=0x3F → RESULT=0x00.
- MUL:
  - A=7, B=9 → RESULT=0x3F, DONE exactly at N+7.
  - Then A=13, B=11 → RESULT=0x0F (143 mod 64).
  - Then B=0 → RESULT=0x00 at N+7.
- MAC chain: after RESULT=0x0F, MAC A=2, B=3 → RESULT=0x15.
  - Repeat with the same operands → 0x1B.
  - After reset, the same MAC → 0x06.
- Handshake:
  - START pulsed in N+3 of a MUL → ignored; exactly one DONE and the original result.
  - START held high continuously → a new command is accepted every 8 cycles (MUL).
- Reset mid-operation: RST in N+4 of a MUL → next cycle BUSY=0, RESULT=0, no DONE; a subsequent ADD 1+1 → 0x02 at normal latency.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared encodings and sizing for the calculator sequencer and its adder.
package calc_pkg;

    localparam int CALC_WIDTH = 6;
    localparam int MUL_ITERS  = 6;
    localparam int CNT_W      = 3;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_MAC = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } state_e;

endpackage

// File: rtl/addandsub.sv
// Combinational modulo-2^WIDTH add/subtract unit; zero latency, no flow control.
module addandsub #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SUB_SEL,
    output logic [WIDTH-1:0] S
);

    assign S = SUB_SEL ? (A - B) : (A + B);

endmodule

// File: rtl/calc_seq.sv
// Sequences ADD/SUB (latency 2) and shift-and-add MUL/MAC (latency 7) on one shared adder.
// START is taken only in IDLE; requests while BUSY or in FIN are dropped, not queued.
module calc_seq
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] A_DATA,
    input  logic [WIDTH-1:0] B_DATA,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT
);

    state_e             state;
    state_e             state_nxt;
    op_e                op_q;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   result_q;
    logic [CNT_W-1:0]   cnt;

    logic               is_mul;
    logic               start_mul;
    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic               add_sub;
    logic [WIDTH-1:0]   add_s;
    logic [WIDTH-1:0]   acc_nxt;

    assign is_mul    = (op_q == OP_MUL) || (op_q == OP_MAC);
    assign start_mul = (op_e'(OP) == OP_MUL) || (op_e'(OP) == OP_MAC);

    // Multiply iterations accumulate acc + shifted multiplicand; ADD/SUB combine the raw operands.
    assign add_a   = is_mul ? acc   : mcand;
    assign add_b   = is_mul ? mcand : mplier;
    assign add_sub = (op_q == OP_SUB);

    addandsub #(
        .WIDTH (WIDTH)
    ) u_addandsub (
        .A       (add_a),
        .B       (add_b),
        .SUB_SEL (add_sub),
        .S       (add_s)
    );

    assign acc_nxt = (is_mul && !mplier[0]) ? acc : add_s;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (START) state_nxt = ST_RUN;
            ST_RUN:  if (cnt == CNT_W'(1)) state_nxt = ST_FIN;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            op_q     <= OP_ADD;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        op_q   <= op_e'(OP);
                        mcand  <= A_DATA;
                        mplier <= B_DATA;
                        acc    <= (op_e'(OP) == OP_MAC) ? result_q : '0;
                        cnt    <= start_mul ? CNT_W'(MUL_ITERS) : CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt - CNT_W'(1);
                    if (is_mul) begin
                        mcand  <= {mcand[WIDTH-2:0], 1'b0};
                        mplier <= {1'b0, mplier[WIDTH-1:1]};
                    end
                    // Publish on the RUN->FIN edge so RESULT is already valid while DONE is high.
                    if (cnt == CNT_W'(1)) begin
                        result_q <= acc_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY   = (state == ST_RUN);
    assign DONE   = (state == ST_FIN);
    assign RESULT = result_q;

endmodule

// File: tb/tb_calc_seq.sv
// Directed bench for calc_seq: stimulus pushes expected results, a negedge monitor checks each DONE.
module tb_calc_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [5:0] a_data;
    logic [5:0] b_data;
    logic       busy;
    logic       done;
    logic [5:0] result;

    typedef struct {
        logic [5:0] res;
        int         t;
    } exp_t;

    exp_t sbq[$];
    int   cyc      = 0;
    int   total    = 0;
    int   bad      = 0;
    int   n_done   = 0;
    int   n_exp    = 0;

    calc_seq #(
        .WIDTH (6)
    ) dut (
        .CLK    (clk),
        .RST    (rst),
        .START  (start),
        .OP     (op),
        .A_DATA (a_data),
        .B_DATA (b_data),
        .BUSY   (busy),
        .DONE   (done),
        .RESULT (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Scoreboard monitor: every DONE must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=RESULT 0x%0h required=no DONE at cycle %0d", result, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("result", int'(result), int'(e.res));
                check("done_cycle", cyc, e.t);
            end
        end
    end

    // Issue one command at the current negedge and step through it, checking BUSY each cycle.
    task automatic issue(input logic [1:0] o, input logic [5:0] a, input logic [5:0] b,
                         input logic [5:0] exp);
        int t0;
        int lat;
        lat    = o[1] ? 7 : 2;
        start  = 1'b1;
        op     = o;
        a_data = a;
        b_data = b;
        t0     = cyc;
        sbq.push_back('{exp, t0 + lat});
        n_exp++;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            check("busy", int'(busy), (k < lat) ? 1 : 0);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst    = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        a_data = '0;
        b_data = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_result", int'(result), 0);
        rst = 1'b0;
        @(negedge clk);

        issue(2'b00, 6'h25, 6'h1A, 6'h3F);
        issue(2'b01, 6'h05, 6'h07, 6'h3E);
        issue(2'b01, 6'h3F, 6'h3F, 6'h00);
        issue(2'b10, 6'd7,  6'd9,  6'h3F);
        issue(2'b10, 6'd13, 6'd11, 6'h0F);
        issue(2'b11, 6'd2,  6'd3,  6'h15);
        issue(2'b11, 6'd2,  6'd3,  6'h1B);
        issue(2'b10, 6'd21, 6'd0,  6'h00);

        // START pulsed mid-MUL must be dropped.
        start = 1'b1; op = 2'b10; a_data = 6'd3; b_data = 6'd5;
        t0 = cyc;
        sbq.push_back('{6'h0F, t0 + 7});
        n_exp++;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; op = 2'b00; a_data = 6'd1; b_data = 6'd1;
        @(negedge clk); start = 1'b0;
        check("busy_after_ignored_start", int'(busy), 1);
        repeat (4) @(negedge clk);
        check("idle_after_pulse_test", int'(busy), 0);

        // START held high: MUL accepted every 8 cycles, never in FIN.
        start = 1'b1; op = 2'b10; a_data = 6'd2; b_data = 6'd3;
        t0 = cyc;
        for (int i = 0; i < 3; i++) begin
            sbq.push_back('{6'h06, t0 + 7 + 8 * i});
            n_exp++;
        end
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 20) start = 1'b0;
            check("held_busy", int'(busy), ((k % 8) >= 1 && (k % 8) <= 6) ? 1 : 0);
        end

        // Full reset, then MAC starts from RESULT=0.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("result_after_reset", int'(result), 0);
        issue(2'b11, 6'd2, 6'd3, 6'h06);

        // Reset in cycle N+4 of a MUL aborts it with no DONE.
        start = 1'b1; op = 2'b10; a_data = 6'd5; b_data = 6'd4;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_result", int'(result), 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        issue(2'b00, 6'd1, 6'd1, 6'h02);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 0);
        check("done_count", n_done, n_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
